// File: rtl/udc_pkg.sv
// udc_counter shared definitions.
// Address map, reset values and the round-trip budget helper.
package udc_pkg;

  localparam int W = 8;

  localparam logic [1:0] ADDR_PLR = 2'd0;
  localparam logic [1:0] ADDR_ULR = 2'd1;
  localparam logic [1:0] ADDR_LLR = 2'd2;
  localparam logic [1:0] ADDR_CCR = 2'd3;

  localparam logic [W-1:0] PLR_RST = '0;
  localparam logic [W-1:0] ULR_RST = 8'hFF;
  localparam logic [W-1:0] LLR_RST = '0;
  localparam logic [W-1:0] CCR_RST = '0;

  typedef enum logic {
    S_IDLE,
    S_COUNT
  } state_t;

  // Number of cycles with cout==plr before end-of-count.
  function automatic logic [W:0] budget(
    input logic [W-1:0] plr,
    input logic [W-1:0] ulr,
    input logic [W-1:0] llr,
    input logic [W-1:0] ccr
  );
    logic eu;
    logic el;
    eu = (plr == ulr);
    el = (plr == llr);
    unique case (1'b1)
      eu && el: budget = {1'b0, ccr};
      eu ^ el:  budget = {1'b0, ccr} + 1'b1;
      default:  budget = {ccr, 1'b1};
    endcase
  endfunction

endpackage

// File: rtl/udc_if.sv
// udc_counter host bus control strobes.
// The bidirectional data bus stays a plain inout port.
interface udc_if;
  logic ncs;
  logic nrd;
  logic nwr;
  logic a1;
  logic a0;

  modport master (
    output ncs, nrd, nwr, a1, a0
  );

  modport slave (
    input ncs, nrd, nwr, a1, a0
  );
endinterface

// File: rtl/udc_regfile.sv
// udc_counter host register file.
// Holds PLR/ULR/LLR/CCR, drives reads onto din, flags bad configs.
module udc_regfile
  import udc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  udc_if.slave         bus,
  input  logic         idle,
  inout  wire  [W-1:0] din,
  output logic [W-1:0] plr,
  output logic [W-1:0] ulr,
  output logic [W-1:0] llr,
  output logic [W-1:0] ccr,
  output logic         err
);

  logic [1:0]   addr;
  logic         wr_en;
  logic         rd_en;
  logic [W-1:0] rdata;

  assign addr  = {bus.a1, bus.a0};
  assign wr_en = !bus.ncs && !bus.nwr && idle;
  assign rd_en = !bus.ncs && !bus.nrd && bus.nwr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      plr <= PLR_RST;
      ulr <= ULR_RST;
      llr <= LLR_RST;
      ccr <= CCR_RST;
      err <= 1'b0;
    end else begin
      if (wr_en) begin
        unique case (addr)
          ADDR_PLR: plr <= din;
          ADDR_ULR: ulr <= din;
          ADDR_LLR: llr <= din;
          ADDR_CCR: ccr <= din;
        endcase
      end
      // Deselect freezes err along with the registers.
      if (idle && !bus.ncs)
        err <= (plr > ulr) || (plr < llr);
    end
  end

  always_comb begin
    rdata = '0;
    unique case (addr)
      ADDR_PLR: rdata = plr;
      ADDR_ULR: rdata = ulr;
      ADDR_LLR: rdata = llr;
      ADDR_CCR: rdata = ccr;
    endcase
  end

  assign din = rd_en ? rdata : 'z;

endmodule

// File: rtl/udc_counter.sv
// udc_counter top: start-edge detect and bounce-count FSM.
// Counts from PLR between LLR and ULR for CCR round trips.
module udc_counter
  import udc_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  udc_if.slave         bus,
  inout  wire  [W-1:0] din,
  input  logic         start,
  output logic [W-1:0] cout,
  output logic         dir,
  output logic         err,
  output logic         ec
);

  state_t       state;
  state_t       state_n;
  logic [1:0]   hist;
  logic [W:0]   n;
  logic [W:0]   n_n;
  logic [W-1:0] cout_n;
  logic [W-1:0] step;
  logic         dir_n;
  logic [W-1:0] plr;
  logic [W-1:0] ulr;
  logic [W-1:0] llr;
  logic [W-1:0] ccr;
  logic         idle;
  logic         hold;
  logic         hit;
  logic         accept;

  udc_regfile u_regs (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .idle  (idle),
    .din   (din),
    .plr   (plr),
    .ulr   (ulr),
    .llr   (llr),
    .ccr   (ccr),
    .err   (err)
  );

  assign idle = (state == S_IDLE);
  assign hold = (plr == ulr) && (plr == llr);
  assign hit  = (cout == plr);

  assign accept = idle && !bus.ncs && !err
               && ({hist, start} == 3'b010)
               && (ccr != '0);

  assign ec = (state == S_COUNT) && hit
           && (n == {{W{1'b0}}, 1'b1});

  assign step = hold ? cout
              : dir  ? cout + 1'b1
              :        cout - 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_IDLE;
      cout  <= '0;
      dir   <= 1'b0;
      n     <= '0;
      hist  <= '0;
    end else begin
      state <= state_n;
      cout  <= cout_n;
      dir   <= dir_n;
      n     <= n_n;
      hist  <= {hist[0], bus.ncs ? 1'b0 : start};
    end
  end

  always_comb begin
    state_n = state;
    cout_n  = '0;
    dir_n   = dir;
    n_n     = n;
    if (bus.ncs || ec) begin
      state_n = S_IDLE;
      dir_n   = 1'b0;
      n_n     = '0;
    end else if (idle) begin
      if (accept) begin
        state_n = S_COUNT;
        cout_n  = plr;
        dir_n   = (plr != ulr);
        n_n     = budget(plr, ulr, llr, ccr);
      end
    end else begin
      // dir shows the turn on the same cycle cout hits a limit.
      cout_n = step;
      if (step == ulr)
        dir_n = 1'b0;
      else if (step == llr)
        dir_n = 1'b1;
      if (hit)
        n_n = n - 1'b1;
    end
  end

endmodule

// File: tb/tb_udc_counter.sv
// udc_counter bench: directed runs with a scoreboard.
// Expected cycles are queued by stimulus, popped by the monitor.
module tb_udc_counter;
  import udc_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_d = '0;
  wire  [7:0] din;
  logic [7:0] cout;
  logic       dir;
  logic       err;
  logic       ec;

  udc_if bus ();

  assign din = tb_oe ? tb_d : 8'bz;

  udc_counter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .din   (din),
    .start (start),
    .cout  (cout),
    .dir   (dir),
    .err   (err),
    .ec    (ec)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] c;
    logic       d;
    logic       e;
    logic       r;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rd_q[$];
  exp_t       x;
  logic [7:0] rv;
  int         n_chk = 0;
  int         n_fail = 0;
  int         tmo_cnt = 0;
  int         tmo_seen = 0;

  always @(negedge clk) begin
    if (tmo_cnt != tmo_seen) begin
      tmo_seen = tmo_cnt;
      n_chk++;
      n_fail++;
      $display("FAIL drain: queue not consumed, want empty");
    end
    if (exp_q.size() != 0) begin
      x = exp_q.pop_front();
      n_chk++;
      if ({cout, dir, ec, err} !== x) begin
        n_fail++;
        $display("FAIL cnt: got c=%0d d=%0b ec=%0b err=%0b want c=%0d d=%0b ec=%0b err=%0b",
                 cout, dir, ec, err, x.c, x.d, x.e, x.r);
      end
    end
    if (!bus.ncs && !bus.nrd && bus.nwr) begin
      n_chk++;
      if (rd_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd: got %0d want no read", din);
      end else begin
        rv = rd_q.pop_front();
        if (din !== rv) begin
          n_fail++;
          $display("FAIL rd: got %0d want %0d", din, rv);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] v);
    tick;
    {bus.a1, bus.a0} = a;
    tb_d = v;
    tb_oe = 1'b1;
    bus.nwr = 1'b0;
    tick;
    bus.nwr = 1'b1;
    tb_oe = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] v);
    tick;
    {bus.a1, bus.a0} = a;
    rd_q.push_back(v);
    bus.nrd = 1'b0;
    tick;
    bus.nrd = 1'b1;
  endtask

  task automatic cfg(input logic [7:0] p, u, l, c);
    wr(ADDR_PLR, p);
    wr(ADDR_ULR, u);
    wr(ADDR_LLR, l);
    wr(ADDR_CCR, c);
  endtask

  task automatic rd_all(input logic [7:0] p, u, l, c);
    rd(ADDR_PLR, p);
    rd(ADDR_ULR, u);
    rd(ADDR_LLR, l);
    rd(ADDR_CCR, c);
  endtask

  // Ends just after the edge that accepts the start.
  task automatic pulse;
    tick;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
  endtask

  task automatic push(input logic [7:0] c, input logic d, e, r);
    exp_q.push_back({c, d, e, r});
  endtask

  task automatic up(input int lo, input int hi, input logic d);
    for (int v = lo; v <= hi; v++) push(8'(v), d, 1'b0, 1'b0);
  endtask

  task automatic down(input int hi, input int lo, input logic d);
    for (int v = hi; v >= lo; v--) push(8'(v), d, 1'b0, 1'b0);
  endtask

  task automatic drain;
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 3000) begin
      @(posedge clk);
      b++;
    end
    if (exp_q.size() != 0) begin
      tmo_cnt++;
      exp_q.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1);
  end

  initial begin
    bus.ncs = 1'b0;
    bus.nrd = 1'b1;
    bus.nwr = 1'b1;
    bus.a1  = 1'b0;
    bus.a0  = 1'b0;
    repeat (3) tick;
    push(8'd0, 1'b0, 1'b0, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    reset = 1'b1;
    drain;
    rd_all(8'd0, 8'd255, 8'd0, 8'd0);

    // Bounce with one round trip.
    cfg(8'd5, 8'd15, 8'd1, 8'd1);
    rd_all(8'd5, 8'd15, 8'd1, 8'd1);
    pulse;
    push(8'd5, 1'b1, 1'b0, 1'b0);
    up(6, 14, 1'b1);
    push(8'd15, 1'b0, 1'b0, 1'b0);
    down(14, 2, 1'b0);
    push(8'd1, 1'b1, 1'b0, 1'b0);
    up(2, 4, 1'b1);
    push(8'd5, 1'b1, 1'b1, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    drain;

    // Preset at the upper limit.
    cfg(8'd10, 8'd10, 8'd1, 8'd2);
    pulse;
    push(8'd10, 1'b0, 1'b0, 1'b0);
    down(9, 2, 1'b0);
    push(8'd1, 1'b1, 1'b0, 1'b0);
    up(2, 9, 1'b1);
    push(8'd10, 1'b0, 1'b0, 1'b0);
    down(9, 2, 1'b0);
    push(8'd1, 1'b1, 1'b0, 1'b0);
    up(2, 9, 1'b1);
    push(8'd10, 1'b0, 1'b1, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    drain;

    // All limits equal: cout holds.
    cfg(8'd9, 8'd9, 8'd9, 8'd5);
    pulse;
    repeat (4) push(8'd9, 1'b0, 1'b0, 1'b0);
    push(8'd9, 1'b0, 1'b1, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    drain;

    // Bad config blocks start.
    cfg(8'd1, 8'd2, 8'd3, 8'd5);
    pulse;
    repeat (3) push(8'd0, 1'b0, 1'b0, 1'b1);
    drain;

    cfg(8'd100, 8'd101, 8'd99, 8'd1);
    pulse;
    push(8'd100, 1'b1, 1'b0, 1'b0);
    push(8'd101, 1'b0, 1'b0, 1'b0);
    push(8'd100, 1'b0, 1'b0, 1'b0);
    push(8'd99, 1'b1, 1'b0, 1'b0);
    push(8'd100, 1'b1, 1'b1, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    drain;

    // Zero cycle count blocks start.
    wr(ADDR_CCR, 8'd0);
    pulse;
    repeat (3) push(8'd0, 1'b0, 1'b0, 1'b0);
    drain;

    // Reset mid-count.
    wr(ADDR_CCR, 8'd2);
    pulse;
    push(8'd100, 1'b1, 1'b0, 1'b0);
    push(8'd101, 1'b0, 1'b0, 1'b0);
    push(8'd100, 1'b0, 1'b0, 1'b0);
    push(8'd99, 1'b1, 1'b0, 1'b0);
    repeat (3) tick;
    reset = 1'b0;
    push(8'd0, 1'b0, 1'b0, 1'b0);
    tick;
    reset = 1'b1;
    drain;
    rd_all(8'd0, 8'd255, 8'd0, 8'd0);

    // Deselect mid-count.
    cfg(8'd5, 8'd15, 8'd1, 8'd1);
    pulse;
    push(8'd5, 1'b1, 1'b0, 1'b0);
    push(8'd6, 1'b1, 1'b0, 1'b0);
    push(8'd7, 1'b1, 1'b0, 1'b0);
    repeat (2) tick;
    bus.ncs = 1'b1;
    push(8'd0, 1'b0, 1'b0, 1'b0);
    push(8'd0, 1'b0, 1'b0, 1'b0);
    tick;
    tick;
    bus.ncs = 1'b0;
    drain;
    rd_all(8'd5, 8'd15, 8'd1, 8'd1);

    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
